viterbi_acs_step: RTL and testbench
===================================

VITERBI_ACS_STEP -- requirements
Module: viterbi_acs_step

Interface
REQ-001 The parameters SHALL be: POS_num, default 11, number of POS tags; POS_num_bit, default 4, tag index width; p_size, default 32, cost width.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  request one word time-step; sampled only in IDLE.
REQ-005 Port: first  in  1  sampled with start; 1 = first word, all previous costs treated as 0.
REQ-006 Port: previous_POS_out  out  POS_num_bit  previous-tag index driven to the transition lookup.
REQ-007 Port: current_POS_out  out  POS_num_bit  current-tag index driven to the transition and emission lookups.
REQ-008 Port: trans_p  in  p_size  transition cost for (previous_POS_out, current_POS_out), valid in the same cycle.
REQ-009 Port: emit_p  in  p_size  emission cost for current_POS_out of the current word, valid in the same cycle.
REQ-010 Port: bp_valid  out  1  one-cycle strobe per current tag.
REQ-011 Port: bp_prev  out  POS_num_bit  best previous tag (backpointer) for current_POS_out while bp_valid=1.
REQ-012 Port: bp_cost  out  p_size  new path cost for current_POS_out while bp_valid=1.
REQ-013 Port: busy  out  1  high from the first ACC cycle through the final WRITE cycle.
REQ-014 Port: done  out  1  one-cycle pulse when the step is complete.
REQ-015 Port: best_pos  out  POS_num_bit  lowest-cost tag of the latest completed step; held until next done.

Function
REQ-016 Costs SHALL be unsigned negative-log values; lower is better.
REQ-017 States: IDLE, ACC, WRITE, DONE; IDLE->ACC on start=1, ACC->WRITE when prev index = POS_num-1, WRITE->ACC if cur < POS_num-1 else WRITE->DONE, DONE->IDLE unconditionally.
REQ-018 In ACC, one (cur, prev) pair per cycle, prev counting 0..POS_num-1 for each cur counting 0..POS_num-1.
REQ-019 ACC SHALL compute sum = delta_prev[prev] + trans_p, saturating at 2^p_size-1.
REQ-020 Running minimum SHALL update only on strict less-than; ties keep the lower prev index.
REQ-021 In WRITE, delta_cur[cur] = saturating(min + emit_p); bp_valid=1, bp_prev = argmin, bp_cost = that value, current_POS_out = cur.
REQ-022 Latency: done asserts exactly POS_num*(POS_num+1) cycles after the start-sampling edge (132 for default).
REQ-023 At the DONE edge, delta_cur SHALL become delta_prev (bank swap) and best_pos SHALL update (ties -> lowest index).
REQ-024 start while busy or in DONE SHALL be ignored; no queuing.
REQ-025 previous_POS_out and current_POS_out SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force IDLE, clear both delta banks to 0, clear counters, and drive busy, done, bp_valid, bp_prev, bp_cost, best_pos and the POS outputs to 0.
REQ-027 Reset during ACC/WRITE SHALL abort the step; no further bp_valid or done until a new start.

Structure
REQ-028 POS_num, POS_num_bit, p_size and the state encoding SHALL live in shared package viterbi_pkg.
REQ-029 The ping-pong delta storage SHALL be sub-module viterbi_delta_bank (two POS_num x p_size banks, bank-select flip on swap).
REQ-030 The transition lookup SHALL remain external and combinational; no internal copy of the matrix.

Verification
REQ-031 first=1, trans_p = 10*prev+cur, emit_p=5 -> bp_prev=0 and bp_cost=cur+5 for every cur; done at cycle 132; best_pos=0.
REQ-032 Second step, first=0, all trans_p=1, emit_p=0 -> bp_cost = delta_prev min +1 = 6, bp_prev=0 (tie rule).
REQ-033 delta_prev[3]=0xFFFFFFF0, trans_p=0x20, all other deltas 0xFFFFFFFF -> sum saturates to 0xFFFFFFFF; emit_p>0 keeps 0xFFFFFFFF.
REQ-034 start pulsed at cycles 5 and 131 of a running step -> ignored; exactly 11 bp_valid strobes and one done.
REQ-035 rst_n low at cycle 40 -> all outputs 0 within the same cycle; new start with first=0 sees delta_prev all 0.
REQ-036 Costs for cur=2 make prev=7 strictly minimal -> bp_prev=7; equal minimum at prev 4 and 7 -> bp_prev=4.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi add-compare-select step.
// Holds the default tag count, index width and cost width, plus the
// controller state encoding so the datapath, the delta storage and any
// checker bound to them agree on a single definition.
package viterbi_pkg;

    localparam int POS_num     = 11;  // number of POS tags
    localparam int POS_num_bit = 4;   // tag index width
    localparam int p_size      = 32;  // path cost width

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/viterbi_delta_bank.sv
// Ping-pong path-cost storage.
// Two banks of n_entries x width costs. One bank is the "previous" bank
// (read side), the other the "current" bank (write side). A one-cycle
// swap pulse flips which is which, so the costs written during a step
// become the previous costs of the next step without any copying.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears both banks)
//   rd_addr    : previous-bank read index
//   rd_data    : previous-bank cost at rd_addr (0 for out-of-range index)
//   wr_en      : write wr_data into the current bank at wr_addr
//   swap       : exchange the roles of the two banks
module viterbi_delta_bank #(
    parameter int n_entries = 11,
    parameter int addr_w    = 4,
    parameter int width     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic              swap
);

    logic [width-1:0] bank0 [n_entries];
    logic [width-1:0] bank1 [n_entries];
    logic             sel;  // 0: bank0 is previous, bank1 is current

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < n_entries) begin
            rd_data = sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
            for (int i = 0; i < n_entries; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (wr_en && (int'(wr_addr) < n_entries)) begin
                if (sel) bank0[wr_addr] <= wr_data;
                else     bank1[wr_addr] <= wr_data;
            end
            if (swap) sel <= ~sel;
        end
    end

endmodule

// File: rtl/viterbi_acs_step.sv
// One Viterbi time-step (add-compare-select) for a POS tagger.
// For every current tag it scans all previous tags, one per cycle,
// accumulating delta_prev[prev] + trans_p with saturation and keeping the
// strictly smallest sum (ties keep the lower prev). A WRITE cycle then adds
// the emission cost, stores the new delta and strobes the backpointer.
// Ports:
//   start/first          : launch a step (IDLE only); first=1 treats prior costs as 0
//   previous_POS_out,
//   current_POS_out      : indices driven to the external cost lookups
//   trans_p, emit_p      : combinational lookup results for those indices
//   bp_valid/bp_prev/
//   bp_cost              : per-current-tag backpointer and new cost
//   busy, done           : step in progress / one-cycle completion pulse
//   best_pos             : lowest-cost tag of the last completed step
//   fsm_state            : controller state, for observation only
// Handshake: start is a level sampled on a rising edge while IDLE; it is
// ignored in every other state and never queued.
module viterbi_acs_step #(
    parameter int POS_num     = viterbi_pkg::POS_num,
    parameter int POS_num_bit = viterbi_pkg::POS_num_bit,
    parameter int p_size      = viterbi_pkg::p_size
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   first,
    output logic [POS_num_bit-1:0] previous_POS_out,
    output logic [POS_num_bit-1:0] current_POS_out,
    input  logic [p_size-1:0]      trans_p,
    input  logic [p_size-1:0]      emit_p,
    output logic                   bp_valid,
    output logic [POS_num_bit-1:0] bp_prev,
    output logic [p_size-1:0]      bp_cost,
    output logic                   busy,
    output logic                   done,
    output logic [POS_num_bit-1:0] best_pos,
    output logic [1:0]             fsm_state
);

    import viterbi_pkg::*;

    localparam logic [POS_num_bit-1:0] LAST = POS_num_bit'(POS_num - 1);

    logic [1:0]             state;
    logic [POS_num_bit-1:0] prev_cnt, cur_cnt;
    logic                   first_q;
    logic [p_size-1:0]      min_cost, best_cost;
    logic [POS_num_bit-1:0] min_idx, best_idx;

    logic [p_size-1:0]      delta_rd, prev_val;
    logic [p_size:0]        sum_full, new_full;
    logic [p_size-1:0]      sum_sat, new_cost;

    // Costs are unsigned; an overflow carry pins the result at all-ones.
    assign prev_val = first_q ? '0 : delta_rd;
    assign sum_full = {1'b0, prev_val} + {1'b0, trans_p};
    assign sum_sat  = sum_full[p_size] ? '1 : sum_full[p_size-1:0];
    assign new_full = {1'b0, min_cost} + {1'b0, emit_p};
    assign new_cost = new_full[p_size] ? '1 : new_full[p_size-1:0];

    viterbi_delta_bank #(
        .n_entries (POS_num),
        .addr_w    (POS_num_bit),
        .width     (p_size)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (prev_cnt),
        .rd_data (delta_rd),
        .wr_en   (state == ST_WRITE),
        .wr_addr (cur_cnt),
        .wr_data (new_cost),
        .swap    (state == ST_DONE)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prev_cnt  <= '0;
            cur_cnt   <= '0;
            first_q   <= 1'b0;
            min_cost  <= '0;
            min_idx   <= '0;
            best_cost <= '0;
            best_idx  <= '0;
            best_pos  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACC;
                        first_q  <= first;
                        prev_cnt <= '0;
                        cur_cnt  <= '0;
                    end
                end
                ST_ACC: begin
                    // prev 0 seeds the running minimum; later prevs replace
                    // it only when strictly smaller.
                    if (prev_cnt == '0 || sum_sat < min_cost) begin
                        min_cost <= sum_sat;
                        min_idx  <= prev_cnt;
                    end
                    if (prev_cnt == LAST) begin
                        prev_cnt <= '0;
                        state    <= ST_WRITE;
                    end else begin
                        prev_cnt <= prev_cnt + POS_num_bit'(1);
                    end
                end
                ST_WRITE: begin
                    // Current tags arrive in ascending order, so strict
                    // less-than yields the lowest index on ties.
                    if (cur_cnt == '0 || new_cost < best_cost) begin
                        best_cost <= new_cost;
                        best_idx  <= cur_cnt;
                    end
                    if (cur_cnt == LAST) begin
                        cur_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cur_cnt <= cur_cnt + POS_num_bit'(1);
                        state   <= ST_ACC;
                    end
                end
                default: begin  // ST_DONE: bank swap happens on this edge
                    best_pos <= best_idx;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        previous_POS_out = '0;
        current_POS_out  = '0;
        bp_valid         = 1'b0;
        bp_prev          = '0;
        bp_cost          = '0;
        if (state == ST_ACC) begin
            previous_POS_out = prev_cnt;
            current_POS_out  = cur_cnt;
        end else if (state == ST_WRITE) begin
            current_POS_out = cur_cnt;
            bp_valid        = 1'b1;
            bp_prev         = min_idx;
            bp_cost         = new_cost;
        end
    end

    assign busy      = (state == ST_ACC) || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_viterbi_acs_step.sv
module tb_viterbi_acs_step;

  localparam int N = 11;
  localparam int AW = 4;
  localparam int P = 32;
  localparam int W = 40;
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          first = 1'b0;
  logic [AW-1:0] previous_POS_out, current_POS_out;
  logic [P-1:0]  trans_p, emit_p;
  logic          bp_valid;
  logic [AW-1:0] bp_prev;
  logic [P-1:0]  bp_cost;
  logic          busy, done;
  logic [AW-1:0] best_pos;
  logic [1:0]    fsm_state;

  logic [P-1:0]  trans_m [N][N];
  logic [P-1:0]  emit_v [N];

  longint        dp [N];      // model: previous costs
  longint        ncost [N];   // model: costs of the step being run
  int            exp_best = 0;
  logic [W-1:0]  exp_q [$];

  int n_checks = 0;
  int n_err = 0;

  viterbi_acs_step dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .first            (first),
    .previous_POS_out (previous_POS_out),
    .current_POS_out  (current_POS_out),
    .trans_p          (trans_p),
    .emit_p           (emit_p),
    .bp_valid         (bp_valid),
    .bp_prev          (bp_prev),
    .bp_cost          (bp_cost),
    .busy             (busy),
    .done             (done),
    .best_pos         (best_pos),
    .fsm_state        (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // external combinational cost lookups
  always_comb begin
    trans_p = '0;
    emit_p  = '0;
    if (int'(previous_POS_out) < N && int'(current_POS_out) < N) begin
      trans_p = trans_m[previous_POS_out][current_POS_out];
      emit_p  = emit_v[current_POS_out];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: for each current tag, min over prev of saturated
  // (prior cost + transition), first prev wins ties, then add emission.
  task automatic build_expect(input bit f);
    longint s, best;
    int bi;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      best = 0;
      bi = 0;
      for (int p = 0; p < N; p++) begin
        s = (f ? 0 : dp[p]) + longint'(trans_m[p][c]);
        if (s > MAXV) s = MAXV;
        if (p == 0 || s < best) begin
          best = s;
          bi = p;
        end
      end
      best = best + longint'(emit_v[c]);
      if (best > MAXV) best = MAXV;
      ncost[c] = best;
      exp_q.push_back({4'(c), 4'(bi), 32'(best)});
    end
  endtask

  task automatic fill(input longint tv, input longint ev);
    for (int p = 0; p < N; p++)
      for (int c = 0; c < N; c++) trans_m[p][c] = 32'(tv);
    for (int c = 0; c < N; c++) emit_v[c] = 32'(ev);
  endtask

  task automatic fill_random(input int tlim, input int elim);
    for (int p = 0; p < N; p++)
      for (int c = 0; c < N; c++) trans_m[p][c] = 32'($urandom_range(0, tlim));
    for (int c = 0; c < N; c++) emit_v[c] = 32'($urandom_range(0, elim));
  endtask

  // driver + monitor for one step; rst_at >= 0 aborts with a reset
  task automatic run_step(input bit f, input bit inject, input int rst_at);
    int k;
    int strobes;
    int stray;
    bit fin;
    logic [W-1:0] e;
    build_expect(f);
    @(negedge clk);
    start = 1'b1;
    first = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    first = 1'b0;
    k = 0;
    strobes = 0;
    fin = 0;
    while (!fin && k < 300) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_bp_valid", 64'(bp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_bp_prev", 64'(bp_prev), 64'(0));
        check("rst_bp_cost", 64'(bp_cost), 64'(0));
        check("rst_best_pos", 64'(best_pos), 64'(0));
        check("rst_prev_out", 64'(previous_POS_out), 64'(0));
        check("rst_cur_out", 64'(current_POS_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bp_valid || done || busy) stray++;
        end
        check("post_abort_quiet", 64'(stray), 64'(0));
        exp_q.delete();
        for (int i = 0; i < N; i++) dp[i] = 0;
        exp_best = 0;
        return;
      end
      start = (inject && (k == 5 || k == 131)) ? 1'b1 : 1'b0;
      if (k == 0) check("busy_first", 64'(busy), 64'(1));
      if (bp_valid) begin
        strobes++;
        if (exp_q.size() == 0) begin
          check("extra_strobe", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("bp_cur", 64'(current_POS_out), 64'(e[39:36]));
          check("bp_prev", 64'(bp_prev), 64'(e[35:32]));
          check("bp_cost", 64'(bp_cost), 64'(e[31:0]));
        end
      end
      if (done) begin
        check("done_latency", 64'(k), 64'(N * (N + 1)));
        check("busy_at_done", 64'(busy), 64'(0));
        check("pos_out_at_done", 64'({previous_POS_out, current_POS_out}), 64'(0));
        fin = 1;
      end
      k++;
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 64'(0), 64'(1));
    check("strobe_count", 64'(strobes), 64'(N));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    exp_best = 0;
    for (int c = 1; c < N; c++) if (ncost[c] < ncost[exp_best]) exp_best = c;
    for (int c = 0; c < N; c++) dp[c] = ncost[c];
    @(negedge clk);
    check("done_single", 64'(done), 64'(0));
    check("best_pos", 64'(best_pos), 64'(exp_best));
    @(negedge clk);
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) dp[i] = 0;
    fill(0, 0);
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_bp_valid", 64'(bp_valid), 64'(0));
    check("reset_best_pos", 64'(best_pos), 64'(0));
    check("reset_pos_outs", 64'({previous_POS_out, current_POS_out}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // first word: trans = 10*prev+cur, emit 5
    for (int p = 0; p < N; p++)
      for (int c = 0; c < N; c++) trans_m[p][c] = 32'(10 * p + c);
    for (int c = 0; c < N; c++) emit_v[c] = 32'd5;
    run_step(1'b1, 1'b0, -1);

    // second word: uniform transitions, ties resolve to prev 0
    fill(1, 0);
    run_step(1'b0, 1'b0, -1);

    // saturation: seed previous costs near the top of the range
    fill(0, MAXV);
    emit_v[3] = 32'hFFFF_FFF0;
    run_step(1'b1, 1'b0, -1);
    fill(32'h20, 1);
    run_step(1'b0, 1'b0, -1);

    // argmin selection: equal priors, cur 2 strict at prev 7, cur 5 tie 4/7
    fill(0, 100);
    run_step(1'b1, 1'b0, -1);
    fill_random(400, 50);
    for (int p = 0; p < N; p++) begin
      trans_m[p][2] = 32'd50 + 32'($urandom_range(0, 100));
      trans_m[p][5] = 32'd50 + 32'($urandom_range(0, 100));
    end
    trans_m[7][2] = 32'd10;
    trans_m[4][5] = 32'd10;
    trans_m[7][5] = 32'd10;
    run_step(1'b0, 1'b0, -1);

    // random steps, one with tie-heavy small costs, one near saturation
    fill_random(3, 3);
    run_step(1'b0, 1'b0, -1);
    fill_random(1000, 1000);
    run_step(1'b0, 1'b1, -1);
    for (int p = 0; p < N; p++)
      for (int c = 0; c < N; c++) trans_m[p][c] = 32'hFFFF_0000 + 32'($urandom_range(0, 65535));
    run_step(1'b0, 1'b0, -1);
    fill_random(1000, 1000);
    run_step(1'b0, 1'b0, -1);

    // abort by reset mid-step, then restart with cleared priors
    fill_random(500, 500);
    run_step(1'b0, 1'b0, 40);
    fill_random(500, 500);
    run_step(1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
